// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// A one-word holding buffer lets frames stream back-to-back without idle bits.
module piso_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             serial_out,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] act_data_q, act_data_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             act_full_q, act_full_d;
    logic             hold_full_q, hold_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic             xfer;
    logic             last_xfer;
    logic [CntW-1:0]  bit_idx;

    // Forced low during reset so no word is captured while the block is held.
    assign in_ready  = reset_n && !hold_full_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = act_full_q && out_ready;
    assign last_xfer = xfer && (cnt_q == LastCnt);

    always_comb begin
        act_data_d  = act_data_q;
        hold_data_d = hold_data_q;
        act_full_d  = act_full_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        if (last_xfer) begin
            cnt_d = '0;
            if (hold_full_q) begin
                act_data_d  = hold_data_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                act_data_d = in_data;
            end else begin
                act_full_d = 1'b0;
            end
        end else begin
            if (xfer) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (accept) begin
                if (!act_full_q) begin
                    act_data_d = in_data;
                    act_full_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    hold_data_d = in_data;
                    hold_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_data_q  <= '0;
            hold_data_q <= '0;
            act_full_q  <= 1'b0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            act_data_q  <= act_data_d;
            hold_data_q <= hold_data_d;
            act_full_q  <= act_full_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bit_idx = MSB_FIRST ? (LastCnt - cnt_q) : cnt_q;

    assign serial_out = act_full_q && act_data_q[bit_idx];
    assign out_valid  = act_full_q;
    assign out_first  = act_full_q && (cnt_q == '0);
    assign out_last   = act_full_q && (cnt_q == LastCnt);
    assign busy       = act_full_q || hold_full_q;

endmodule

// File: tb/tb_piso_stream.sv
// Randomized + directed bench for piso_stream; MSB-first and LSB-first instances
// share stimulus and are checked against a word-queue reference model.
module tb_piso_stream;

    localparam int unsigned W = 8;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;

    logic in_ready_m, serial_m, out_valid_m, first_m, last_m, busy_m;
    logic in_ready_l, serial_l, out_valid_l, first_l, last_l, busy_l;

    always #5 clock = ~clock;

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .out_ready(out_ready), .serial_out(serial_m),
        .out_valid(out_valid_m), .out_first(first_m), .out_last(last_m), .busy(busy_m)
    );

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_ready(out_ready), .serial_out(serial_l),
        .out_valid(out_valid_l), .out_first(first_l), .out_last(last_l), .busy(busy_l)
    );

    // Reference model: queue of pending words (front = word on the wire) and bit position.
    logic [W-1:0] mq[$];
    int           pos = 0;

    // Bits actually seen on each DUT's wire during a transfer.
    logic cap_m[$];
    logic cap_l[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_bit(input bit msb);
        if (mq.size() == 0) return 1'b0;
        return msb ? mq[0][W-1-pos] : mq[0][pos];
    endfunction

    function automatic logic [31:0] pack_bits(input bit msb_dut);
        logic [31:0] v = '0;
        if (msb_dut) foreach (cap_m[i]) v = {v[30:0], cap_m[i]};
        else         foreach (cap_l[i]) v = {v[30:0], cap_l[i]};
        return v;
    endfunction

    task automatic check_outputs();
        logic exp_rdy, exp_val, exp_first, exp_last;
        exp_rdy   = reset_n && (mq.size() < 2);
        exp_val   = mq.size() > 0;
        exp_first = exp_val && (pos == 0);
        exp_last  = exp_val && (pos == W - 1);
        check_eq("in_ready_msb",  32'(in_ready_m),  32'(exp_rdy));
        check_eq("in_ready_lsb",  32'(in_ready_l),  32'(exp_rdy));
        check_eq("out_valid_msb", 32'(out_valid_m), 32'(exp_val));
        check_eq("out_valid_lsb", 32'(out_valid_l), 32'(exp_val));
        check_eq("serial_msb",    32'(serial_m),    32'(model_bit(1'b1)));
        check_eq("serial_lsb",    32'(serial_l),    32'(model_bit(1'b0)));
        check_eq("first_msb",     32'(first_m),     32'(exp_first));
        check_eq("first_lsb",     32'(first_l),     32'(exp_first));
        check_eq("last_msb",      32'(last_m),      32'(exp_last));
        check_eq("last_lsb",      32'(last_l),      32'(exp_last));
        check_eq("busy_msb",      32'(busy_m),      32'(exp_val));
        check_eq("busy_lsb",      32'(busy_l),      32'(exp_val));
    endtask

    // One clock: check before the edge, advance the model on the edge, release #1 after.
    task automatic step();
        bit acc;
        @(negedge clock);
        check_outputs();
        if (out_valid_m && out_ready) cap_m.push_back(serial_m);
        if (out_valid_l && out_ready) cap_l.push_back(serial_l);
        @(posedge clock);
        if (reset_n) begin
            acc = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) begin
                pos++;
                if (pos == W) begin
                    void'(mq.pop_front());
                    pos = 0;
                end
            end
            if (acc) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        mq.delete();
        pos = 0;
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_cap();
        cap_m.delete();
        cap_l.delete();
    endtask

    initial begin
        // Reset with a word offered: nothing may be captured.
        #1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        out_ready = 1'b1;
        assert_reset();
        steps(3);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        steps(2);

        // Single word 0x1E.
        clear_cap();
        in_valid = 1'b1;
        in_data  = 8'h1E;
        step();
        in_valid = 1'b0;
        steps(10);
        check_eq("single_seq_msb", pack_bits(1'b1), 32'b00011110);
        check_eq("single_seq_lsb", pack_bits(1'b0), 32'b01111000);
        check_eq("single_cnt", 32'(cap_m.size()), 32'd8);

        // Back-to-back 0x3C, 0xC3.
        clear_cap();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        in_data  = 8'hC3;
        step();
        in_valid = 1'b0;
        steps(18);
        check_eq("b2b_seq_msb", pack_bits(1'b1), 32'b0011110011000011);
        check_eq("b2b_cnt", 32'(cap_m.size()), 32'd16);

        // Backpressure on 0xA5.
        clear_cap();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        steps(3);
        out_ready = 1'b0;
        steps(3);
        out_ready = 1'b1;
        steps(7);
        check_eq("bp_seq_msb", pack_bits(1'b1), 32'hA5);
        check_eq("bp_seq_lsb", pack_bits(1'b0), 32'hA5);

        // Reset mid-word with a second word held.
        in_valid = 1'b1;
        in_data  = 8'hF0;
        step();
        in_data  = 8'h0F;
        step();
        in_valid = 1'b0;
        steps(3);
        assert_reset();
        steps(2);
        reset_n = 1'b1;
        steps(1);
        clear_cap();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        steps(10);
        check_eq("post_reset_seq", pack_bits(1'b1), 32'h5A);

        // Random traffic with occasional backpressure and resets.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                step();
                reset_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
